// File: rtl/tm_engine_dram.sv
// tm_engine_dram: table-driven Turing-machine engine with its tape in external DRAM.
// The transition table is written at runtime through tbl_we/tbl_addr/tbl_wdata while
// the engine is idle or done. Optional feature macro: SIGMA_COUNT_EN keeps a running
// count of nonblank tape cells on sigma; without it sigma is tied to zero.
module tm_engine_dram #(
    parameter int ADDR_W  = 16,
    parameter int SYM_W   = 4,
    parameter int STATE_W = 2,
    parameter int COUNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [COUNT_W-1:0]         step_limit,
    input  logic                       tbl_we,
    input  logic [STATE_W+SYM_W-1:0]   tbl_addr,
    input  logic [SYM_W+STATE_W:0]     tbl_wdata,
    output logic                       running,
    output logic                       halted,
    output logic                       timeout,
    output logic [COUNT_W-1:0]         step_count,
    output logic [COUNT_W-1:0]         sigma,
    output logic [ADDR_W-1:0]          head_pos,
    output logic                       m_ena,
    output logic                       m_write,
    output logic [ADDR_W-1:0]          m_addr,
    output logic [SYM_W-1:0]           wr_data,
    input  logic [SYM_W-1:0]           rd_data,
    input  logic                       m_ack,
    input  logic                       m_busy,
    output logic [2:0]                 dbg_state
);
    localparam int ENTRY_W = SYM_W + 1 + STATE_W;
    localparam int TBL_N   = 2 ** (STATE_W + SYM_W);
    localparam logic [STATE_W-1:0] HALT     = '1;
    localparam logic [ADDR_W-1:0]  ADDR_ONE = 1;
    localparam logic [COUNT_W-1:0] CNT_ONE  = 1;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RD, S_LOOK, S_WR, S_MOVE, S_DONE} state_t;
    typedef enum logic [1:0] {P_ISSUE, P_REQ, P_WAIT} phase_t;

    state_t               state, state_nxt;
    phase_t               phase;
    logic [STATE_W-1:0]   tm_state;
    logic [SYM_W-1:0]     sym;
    logic [ENTRY_W-1:0]   entry;
    logic [ADDR_W-1:0]    clr_addr;
    logic [ENTRY_W-1:0]   tbl [TBL_N];

    logic [SYM_W-1:0]     ent_sym;
    logic                 ent_dir;
    logic [STATE_W-1:0]   ent_next;
    logic                 accepting, mem_access, acc_done;
    logic                 stop_halt, stop_limit;
    logic [COUNT_W-1:0]   step_inc;

    assign ent_sym    = entry[ENTRY_W-1 -: SYM_W];
    assign ent_dir    = entry[STATE_W];
    assign ent_next   = entry[STATE_W-1:0];
    assign accepting  = (state == S_IDLE) || (state == S_DONE);
    assign mem_access = (state == S_CLR) || (state == S_RD) || (state == S_WR);
    // Memory handshake: a request is raised only when the controller is not busy, held
    // with stable address/direction/data until the ack cycle, dropped on the next cycle,
    // and the access completes once m_busy is low again; one request in flight at most.
    assign acc_done   = mem_access && (phase == P_WAIT) && !m_busy;
    assign step_inc   = (step_count == '1) ? step_count : step_count + CNT_ONE;
    assign stop_halt  = (ent_next == HALT);
    assign stop_limit = (step_limit != '0) && (step_inc == step_limit);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: sequence CLR sweep, then RD/LOOK/WR/MOVE per step until a stop.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_CLR;
            S_CLR:          if (acc_done && clr_addr == '0) state_nxt = S_RD;
            S_RD:           if (acc_done) state_nxt = S_LOOK;
            S_LOOK:         state_nxt = S_WR;
            S_WR:           if (acc_done) state_nxt = S_MOVE;
            S_MOVE:         state_nxt = (stop_halt || stop_limit) ? S_DONE : S_RD;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs derived from the current state.
    always_comb begin
        running   = !accepting;
        dbg_state = state;
    end

    // DRAM port: issue, hold until ack, then wait for the controller to go idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase   <= P_ISSUE;
            m_ena   <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            wr_data <= '0;
        end else begin
            unique case (phase)
                P_ISSUE: if (mem_access && !m_busy) begin
                    m_ena   <= 1'b1;
                    m_write <= (state != S_RD);
                    m_addr  <= (state == S_CLR) ? clr_addr : head_pos;
                    wr_data <= (state == S_WR) ? ent_sym : '0;
                    phase   <= P_REQ;
                end
                P_REQ: if (m_ack) begin
                    m_ena <= 1'b0;
                    phase <= P_WAIT;
                end
                P_WAIT: if (!m_busy) phase <= P_ISSUE;
                default: phase <= P_ISSUE;
            endcase
        end
    end

    // Machine datapath: clear sweep address, symbol latch, step counter, head and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted     <= 1'b0;
            timeout    <= 1'b0;
            step_count <= '0;
            head_pos   <= '0;
            tm_state   <= '0;
            sym        <= '0;
            clr_addr   <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: if (start) begin
                    halted     <= 1'b0;
                    timeout    <= 1'b0;
                    step_count <= '0;
                    clr_addr   <= '1;
                end
                S_CLR: if (acc_done) begin
                    if (clr_addr == '0) begin
                        head_pos   <= '0;
                        tm_state   <= '0;
                        step_count <= '0;
                    end else begin
                        clr_addr <= clr_addr - ADDR_ONE;
                    end
                end
                S_RD: if (acc_done) sym <= rd_data;
                S_MOVE: begin
                    step_count <= step_inc;
                    tm_state   <= ent_next;
                    if (stop_halt)       halted   <= 1'b1;
                    else if (stop_limit) timeout  <= 1'b1;
                    else if (ent_dir)    head_pos <= head_pos + ADDR_ONE;
                    else                 head_pos <= head_pos - ADDR_ONE;
                end
                default: ;
            endcase
        end
    end

    // Transition table RAM: writable only while stopped, registered read in LOOK.
    always_ff @(posedge clk) begin
        if (tbl_we && accepting) tbl[tbl_addr] <= tbl_wdata;
        if (state == S_LOOK)     entry <= tbl[{tm_state, sym}];
    end

`ifdef SIGMA_COUNT_EN
    // Nonblank-cell count, adjusted when a step turns a blank into a mark or back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sigma <= '0;
        end else if (accepting && start) begin
            sigma <= '0;
        end else if (state == S_MOVE) begin
            if (sym == '0 && ent_sym != '0)      sigma <= sigma + CNT_ONE;
            else if (sym != '0 && ent_sym == '0) sigma <= sigma - CNT_ONE;
        end
    end
`else
    assign sigma = '0;
`endif

endmodule

// File: tb/tb_tm_engine_dram.sv
// tb_tm_engine_dram: bench for tm_engine_dram with a 16-cell tape and a DRAM controller
// model that can stall its ack. Results are compared with a step-by-step machine model.
module tb_tm_engine_dram;
    localparam int AW  = 4;
    localparam int SW  = 4;
    localparam int STW = 2;
    localparam int CW  = 32;
    localparam int EW  = SW + 1 + STW;
    localparam int NT  = 1 << (STW + SW);
    localparam int NC  = 1 << AW;
    localparam int H   = (1 << STW) - 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              tbl_we = 1'b0;
    logic [CW-1:0]     step_limit = '0;
    logic [STW+SW-1:0] tbl_addr = '0;
    logic [EW-1:0]     tbl_wdata = '0;
    logic              running, halted, timeout;
    logic [CW-1:0]     step_count, sigma;
    logic [AW-1:0]     head_pos, m_addr;
    logic              m_ena, m_write;
    logic [SW-1:0]     wr_data, rd_data;
    logic              m_ack = 1'b0;
    logic              m_busy = 1'b0;
    logic [2:0]        dbg_state;

    int n_tests = 0;
    int n_fail = 0;
    int stall_cycles = 0;
    int proto_err = 0;

    // model results
    logic [EW-1:0]    tbl_m [NT];
    logic             exp_halted, exp_timeout;
    logic [CW-1:0]    exp_steps, exp_sigma;
    logic [AW-1:0]    exp_head;
    logic [NC*SW-1:0] exp_tape, dut_tape;

    tm_engine_dram #(.ADDR_W(AW), .SYM_W(SW), .STATE_W(STW), .COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_limit(step_limit),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_wdata(tbl_wdata),
        .running(running), .halted(halted), .timeout(timeout),
        .step_count(step_count), .sigma(sigma), .head_pos(head_pos),
        .m_ena(m_ena), .m_write(m_write), .m_addr(m_addr), .wr_data(wr_data),
        .rd_data(rd_data), .m_ack(m_ack), .m_busy(m_busy), .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // DRAM controller model: optional ack stall, 2-cycle busy after ack
    logic [SW-1:0] dram [NC];
    logic [SW-1:0] rd_q = '0;
    int            busy_cnt = 0;
    int            stall_cnt = 0;
    assign rd_data = rd_q;

    always @(posedge clk) begin
        m_ack <= 1'b0;
        if (!rst_n)
            for (int i = 0; i < NC; i++) dram[i] <= SW'($urandom_range(0, 15));
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) m_busy <= 1'b0;
        end else if (m_ena && !m_ack) begin
            if (stall_cnt < stall_cycles) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
                m_ack     <= 1'b1;
                m_busy    <= 1'b1;
                busy_cnt  <= 2;
                if (m_write) dram[m_addr] <= wr_data;
                else         rd_q <= dram[m_addr];
            end
        end else if (!m_ena) begin
            stall_cnt <= 0;
        end
    end

    // protocol monitor: request held stable until ack, dropped after ack, none while busy
    logic          p_rst = 1'b0, p_ena = 1'b0, p_ack = 1'b0, p_busy = 1'b0, p_write = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [SW-1:0] p_wdata = '0;
    always @(negedge clk) begin
        if (rst_n && p_rst) begin
            if (p_ena && !p_ack &&
                (!m_ena || m_addr != p_addr || m_write != p_write || wr_data != p_wdata))
                proto_err <= proto_err + 1;
            else if (p_ena && p_ack && m_ena)
                proto_err <= proto_err + 1;
            else if (m_ena && !p_ena && p_busy)
                proto_err <= proto_err + 1;
        end
        p_rst <= rst_n; p_ena <= m_ena; p_ack <= m_ack; p_busy <= m_busy;
        p_write <= m_write; p_addr <= m_addr; p_wdata <= wr_data;
    end

    function automatic logic [EW-1:0] mk(input int ns, input bit dir, input int nx);
        return {SW'(ns), dir, STW'(nx)};
    endfunction

    task automatic load_default();
        for (int i = 0; i < NT; i++) tbl_m[i] = mk(0, 1'b1, H);
    endtask

    task automatic set_bb2();
        load_default();
        tbl_m[0]  = mk(1, 1'b1, 1);   // A0 = 1RB
        tbl_m[1]  = mk(1, 1'b0, 1);   // A1 = 1LB
        tbl_m[16] = mk(1, 1'b0, 0);   // B0 = 1LA
        tbl_m[17] = mk(1, 1'b1, H);   // B1 = 1RH
    endtask

    // driver: copy the model table into the DUT
    task automatic write_table();
        for (int i = 0; i < NT; i++) begin
            @(negedge clk);
            tbl_we = 1'b1; tbl_addr = (STW+SW)'(i); tbl_wdata = tbl_m[i];
        end
        @(negedge clk);
        tbl_we = 1'b0;
    endtask

    // reference machine: plain tape array, one loop iteration per transition
    task automatic model_run(input logic [CW-1:0] limit);
        int head, st, steps, ns, cnt;
        logic [SW-1:0] tape [NC];
        logic [EW-1:0] e;
        for (int i = 0; i < NC; i++) tape[i] = '0;
        head = 0; st = 0; steps = 0;
        exp_halted = 1'b0; exp_timeout = 1'b0;
        while (steps < 50000) begin
            e = tbl_m[st * (1 << SW) + int'(tape[head])];
            ns = int'(e[EW-1 -: SW]);
            tape[head] = SW'(ns);
            steps++;
            st = int'(e[STW-1:0]);
            if (st == H) begin exp_halted = 1'b1; break; end
            if (limit != 0 && steps == int'(limit)) begin exp_timeout = 1'b1; break; end
            head = e[STW] ? (head + 1) % NC : (head + NC - 1) % NC;
        end
        exp_steps = CW'(steps);
        exp_head  = AW'(head);
        cnt = 0;
        for (int i = 0; i < NC; i++) begin
            exp_tape[i*SW +: SW] = tape[i];
            if (tape[i] != 0) cnt++;
        end
`ifdef SIGMA_COUNT_EN
        exp_sigma = CW'(cnt);
`else
        exp_sigma = '0;
`endif
    endtask

    // driver: pulse start and wait (bounded) for the run to finish
    task automatic run_dut(input logic [CW-1:0] limit, output bit finished);
        step_limit = limit;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        finished = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (!running) begin finished = 1'b1; break; end
            @(negedge clk);
        end
        for (int i = 0; i < NC; i++) dut_tape[i*SW +: SW] = dram[i];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({m_ena, m_write, running, halted, timeout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000", {m_ena, m_write, running, halted, timeout});
        end
        n_tests++;
        if ({step_count, sigma, head_pos, m_addr, wr_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_values: step=%0d sigma=%0d head=%0d addr=%0d wd=%0d want all 0",
                     step_count, sigma, head_pos, m_addr, wr_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bb2();
        bit fin;
        stall_cycles = 0;
        set_bb2(); write_table();
        model_run('0);
        run_dut('0, fin);
        n_tests++;
        if (!fin) begin n_fail++; $display("FAIL bb2_finish: still running after budget, want done"); end
        n_tests++;
        if ({halted, timeout} !== 2'b10 || exp_halted !== 1'b1) begin
            n_fail++; $display("FAIL bb2_flags: halted=%b timeout=%b want 1 0", halted, timeout);
        end
        n_tests++;
        if (step_count !== exp_steps || head_pos !== exp_head) begin
            n_fail++;
            $display("FAIL bb2_count_head: step=%0d head=%h want %0d %h", step_count, head_pos, exp_steps, exp_head);
        end
        n_tests++;
        if (sigma !== exp_sigma) begin
            n_fail++; $display("FAIL bb2_sigma: got %0d want %0d", sigma, exp_sigma);
        end
        n_tests++;
        if (dut_tape !== exp_tape) begin
            n_fail++; $display("FAIL bb2_tape: got %h want %h", dut_tape, exp_tape);
        end
    endtask

    task automatic test_timeout();
        bit fin;
        set_bb2(); write_table();
        model_run(CW'(3));
        run_dut(CW'(3), fin);
        n_tests++;
        if (!fin || {halted, timeout} !== {exp_halted, exp_timeout}) begin
            n_fail++; $display("FAIL timeout_flags: fin=%b halted=%b timeout=%b want 1 %b %b",
                               fin, halted, timeout, exp_halted, exp_timeout);
        end
        n_tests++;
        if (step_count !== exp_steps || head_pos !== exp_head) begin
            n_fail++;
            $display("FAIL timeout_count_head: step=%0d head=%h want %0d %h", step_count, head_pos, exp_steps, exp_head);
        end
    endtask

    task automatic test_wrap();
        bit fin;
        load_default();
        tbl_m[0] = mk(0, 1'b0, 0);     // A0 = 0LA
        write_table();
        for (int lim = 1; lim <= 2; lim++) begin
            model_run(CW'(lim));
            run_dut(CW'(lim), fin);
            n_tests++;
            if (!fin || timeout !== 1'b1 || step_count !== exp_steps || head_pos !== exp_head) begin
                n_fail++;
                $display("FAIL wrap_limit%0d: fin=%b timeout=%b step=%0d head=%h want 1 1 %0d %h",
                         lim, fin, timeout, step_count, head_pos, exp_steps, exp_head);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int  reads;
        bit  prev, fin;
        set_bb2(); write_table();
        step_limit = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        reads = 0; prev = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (m_ena && !m_write && !prev) reads++;
            prev = m_ena && !m_write;
            if (reads == 3) break;
            @(negedge clk);
        end
        n_tests++;
        if (reads != 3) begin n_fail++; $display("FAIL midrst_reads: saw %0d reads want 3", reads); end
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({m_ena, running, halted, timeout} !== 4'b0 || step_count !== '0 || head_pos !== '0 || sigma !== '0) begin
            n_fail++;
            $display("FAIL midrst_state: ena=%b run=%b step=%0d head=%h sigma=%0d want all 0",
                     m_ena, running, step_count, head_pos, sigma);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        model_run('0);
        run_dut('0, fin);
        n_tests++;
        if (!fin || halted !== 1'b1 || step_count !== exp_steps || head_pos !== exp_head || dut_tape !== exp_tape) begin
            n_fail++;
            $display("FAIL midrst_rerun: fin=%b halted=%b step=%0d head=%h tape=%h want 1 1 %0d %h %h",
                     fin, halted, step_count, head_pos, dut_tape, exp_steps, exp_head, exp_tape);
        end
    endtask

    task automatic test_tbl_we_ignored();
        bit fin;
        set_bb2(); write_table();
        model_run('0);
        step_limit = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (20) @(negedge clk);
        tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = mk(1, 1'b1, H);
        @(negedge clk);
        tbl_we = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (!running) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        n_tests++;
        if (!fin || halted !== 1'b1 || step_count !== exp_steps) begin
            n_fail++;
            $display("FAIL tblwe_running: fin=%b halted=%b step=%0d want 1 1 %0d", fin, halted, step_count, exp_steps);
        end
    endtask

    task automatic test_stall();
        bit fin;
        stall_cycles = 5;
        set_bb2(); write_table();
        model_run('0);
        run_dut('0, fin);
        n_tests++;
        if (!fin || halted !== 1'b1 || step_count !== exp_steps || head_pos !== exp_head ||
            sigma !== exp_sigma || dut_tape !== exp_tape) begin
            n_fail++;
            $display("FAIL stall_result: fin=%b halted=%b step=%0d head=%h sigma=%0d want 1 1 %0d %h %0d",
                     fin, halted, step_count, head_pos, sigma, exp_steps, exp_head, exp_sigma);
        end
        stall_cycles = 0;
    endtask

    task automatic test_random();
        bit fin;
        logic [CW-1:0] lim;
        for (int it = 0; it < 8; it++) begin
            load_default();
            for (int s = 0; s < 3; s++)
                for (int y = 0; y < 4; y++)
                    tbl_m[s * (1 << SW) + y] = mk($urandom_range(0, 3), 1'($urandom_range(0, 1)),
                                                   $urandom_range(0, 3));
            lim = CW'($urandom_range(1, 40));
            stall_cycles = $urandom_range(0, 3);
            write_table();
            model_run(lim);
            run_dut(lim, fin);
            n_tests++;
            if (!fin || {halted, timeout} !== {exp_halted, exp_timeout} || step_count !== exp_steps ||
                head_pos !== exp_head || sigma !== exp_sigma || dut_tape !== exp_tape) begin
                n_fail++;
                $display("FAIL random_%0d: h=%b t=%b step=%0d head=%h sigma=%0d tape=%h want %b %b %0d %h %0d %h",
                         it, halted, timeout, step_count, head_pos, sigma, dut_tape,
                         exp_halted, exp_timeout, exp_steps, exp_head, exp_sigma, exp_tape);
            end
        end
        stall_cycles = 0;
    endtask

    task automatic test_protocol();
        n_tests++;
        if (proto_err !== 0) begin
            n_fail++; $display("FAIL mem_protocol: %0d violations want 0", proto_err);
        end
    endtask

    initial begin
        test_reset();
        do_reset();
        test_bb2();
        test_timeout();
        test_wrap();
        test_reset_mid_run();
        test_tbl_we_ignored();
        test_stall();
        test_random();
        test_protocol();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
